// File: rtl/tpu_axi_pkg.sv
// Shared definitions for the TPU matrix loader.
// Holds the loader FSM state encoding, the AXI4 read-channel constants the
// loader drives or checks, and the matrix-size limit.
package tpu_axi_pkg;

    localparam int          MAX_MATRIX_SIZE = 16;

    localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_FIN  = 2'd3
    } ld_state_e;

    // N is legal when 1 <= N <= max_n.
    function automatic logic size_ok(input logic [4:0] n, input int max_n);
        return (n != 5'd0) && (int'({27'd0, n}) <= max_n);
    endfunction

endpackage

// File: rtl/tpu_matrix_loader_if.sv
// AXI4 read-address and read-data channels used by the matrix loader.
// master: loader side (drives AR*, RREADY); slave: memory/fabric side.
interface tpu_matrix_loader_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 1
) ();
    logic [ID_W-1:0]   M_AXI_ARID;
    logic [ADDR_W-1:0] M_AXI_ARADDR;
    logic [7:0]        M_AXI_ARLEN;
    logic [2:0]        M_AXI_ARSIZE;
    logic [1:0]        M_AXI_ARBURST;
    logic              M_AXI_ARVALID;
    logic              M_AXI_ARREADY;
    logic [ID_W-1:0]   M_AXI_RID;
    logic [DATA_W-1:0] M_AXI_RDATA;
    logic [1:0]        M_AXI_RRESP;
    logic              M_AXI_RLAST;
    logic              M_AXI_RVALID;
    logic              M_AXI_RREADY;

    modport master (
        output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        output M_AXI_ARVALID, M_AXI_RREADY,
        input  M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        input  M_AXI_RVALID
    );

    modport slave (
        input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
        input  M_AXI_ARVALID, M_AXI_RREADY,
        output M_AXI_ARREADY, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST,
        output M_AXI_RVALID
    );
endinterface

// File: rtl/tpu_matrix_loader_burst_gen.sv
// Burst generator for the matrix loader (module tpu_burst_gen).
// Purely combinational: from the latched base address, the index of the next
// burst and the number of words still to request, produce the burst size.
//   base       : matrix base byte address
//   burst_idx  : 0-based burst number
//   remaining  : words not yet requested (>= 1 when used)
//   beats      : min(BURST_LEN, remaining)
//   arlen      : beats-1
//   araddr     : base + burst_idx * BURST_LEN * bytes-per-beat
module tpu_burst_gen #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 16
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [4:0]        burst_idx,
    input  logic [8:0]        remaining,
    output logic [8:0]        beats,
    output logic [7:0]        arlen,
    output logic [ADDR_W-1:0] araddr
);
    // Every burst but the last is full, so burst k starts k full strides in.
    localparam int STRIDE = BURST_LEN * (DATA_W / 8);

    always_comb begin
        beats  = (remaining > 9'(BURST_LEN)) ? 9'(BURST_LEN) : remaining;
        arlen  = 8'(beats - 9'd1);
        araddr = base + ADDR_W'(burst_idx) * ADDR_W'(STRIDE);
    end
endmodule

// File: rtl/tpu_matrix_loader.sv
// TPU matrix loader: fetches an NxN matrix of 32-bit words over AXI4 read
// bursts (at most one outstanding) and streams it, row-major, into an element
// buffer.
//   ACLK/ARESET         : clock, synchronous active-high reset
//   start/base_addr/
//   matrix_size         : load request, 64-byte aligned base, N
//   busy/done/error     : status (done is a one-cycle pulse, error is sticky
//                         until the next accepted start)
//   buf_wr_*            : element buffer write port
//   m_axi               : AXI4 read master (AR + R channels)
module tpu_matrix_loader
    import tpu_axi_pkg::*;
#(
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ID_WIDTH   = 1,
    parameter int C_M_AXI_BURST_LEN  = 16,
    parameter int MAX_MATRIX_SIZE    = tpu_axi_pkg::MAX_MATRIX_SIZE
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic                          start,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0] base_addr,
    input  logic [4:0]                    matrix_size,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic                          buf_wr_en,
    output logic [7:0]                    buf_wr_addr,
    output logic [C_M_AXI_DATA_WIDTH-1:0] buf_wr_data,
    tpu_matrix_loader_if.master           m_axi
);
    ld_state_e                     state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0] base_q, base_d;
    logic [8:0]                    total_q, total_d;     // N*N
    logic [8:0]                    issued_q, issued_d;   // words requested so far
    logic [4:0]                    burst_idx_q, burst_idx_d;
    logic [7:0]                    beat_cnt_q, beat_cnt_d;
    logic [7:0]                    len_q, len_d;         // ARLEN of the burst in flight
    logic [8:0]                    wr_idx_q, wr_idx_d;
    logic                          err_q, err_d;

    logic [8:0]                    gen_beats;
    logic [7:0]                    gen_arlen;
    logic [C_M_AXI_ADDR_WIDTH-1:0] gen_araddr;
    logic                          wr_en;
    logic                          last_beat;
    logic                          beat_bad;

    tpu_burst_gen #(
        .ADDR_W    (C_M_AXI_ADDR_WIDTH),
        .DATA_W    (C_M_AXI_DATA_WIDTH),
        .BURST_LEN (C_M_AXI_BURST_LEN)
    ) u_burst_gen (
        .base      (base_q),
        .burst_idx (burst_idx_q),
        .remaining (total_q - issued_q),
        .beats     (gen_beats),
        .arlen     (gen_arlen),
        .araddr    (gen_araddr)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        total_d     = total_q;
        issued_d    = issued_q;
        burst_idx_d = burst_idx_q;
        beat_cnt_d  = beat_cnt_q;
        len_d       = len_q;
        wr_idx_d    = wr_idx_q;
        err_d       = err_q;
        wr_en       = 1'b0;

        // Burst length is counted, never taken from RLAST; an RLAST that
        // disagrees with the count is itself an error.
        last_beat = (beat_cnt_q == len_q);
        beat_bad  = (m_axi.M_AXI_RRESP != AXI_RESP_OKAY) ||
                    (m_axi.M_AXI_RLAST != last_beat);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    total_d     = 9'(matrix_size) * 9'(matrix_size);
                    issued_d    = 9'd0;
                    burst_idx_d = 5'd0;
                    wr_idx_d    = 9'd0;
                    err_d       = 1'b0;
                    if (size_ok(matrix_size, MAX_MATRIX_SIZE)) begin
                        state_d = ST_AR;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_FIN;
                    end
                end
            end
            ST_AR: begin
                if (m_axi.M_AXI_ARREADY) begin
                    issued_d    = issued_q + gen_beats;
                    burst_idx_d = burst_idx_q + 5'd1;
                    len_d       = gen_arlen;
                    beat_cnt_d  = 8'd0;
                    state_d     = ST_R;
                end
            end
            ST_R: begin
                if (m_axi.M_AXI_RVALID) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    // Once the load has failed, the rest of the burst is drained
                    // but never written.
                    if (beat_bad) begin
                        err_d = 1'b1;
                    end else if (!err_q) begin
                        wr_en    = 1'b1;
                        wr_idx_d = wr_idx_q + 9'd1;
                    end
                    if (last_beat) begin
                        state_d = (err_q || beat_bad || issued_q == total_q) ? ST_FIN : ST_AR;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            burst_idx_q <= '0;
            beat_cnt_q  <= '0;
            len_q       <= '0;
            wr_idx_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            total_q     <= total_d;
            issued_q    <= issued_d;
            burst_idx_q <= burst_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            len_q       <= len_d;
            wr_idx_q    <= wr_idx_d;
            err_q       <= err_d;
        end
    end

    // Outputs decode from state; address/data buses are zeroed when not
    // qualified so they read as 0 straight after reset.
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign error       = err_q;
    assign buf_wr_en   = wr_en;
    assign buf_wr_addr = wr_en ? wr_idx_q[7:0] : 8'd0;
    assign buf_wr_data = wr_en ? m_axi.M_AXI_RDATA : '0;

    assign m_axi.M_AXI_ARID    = {C_M_AXI_ID_WIDTH{1'b0}};
    assign m_axi.M_AXI_ARSIZE  = AXI_SIZE_4B;
    assign m_axi.M_AXI_ARBURST = AXI_BURST_INCR;
    assign m_axi.M_AXI_ARVALID = (state_q == ST_AR);
    assign m_axi.M_AXI_ARADDR  = (state_q == ST_AR) ? gen_araddr : '0;
    assign m_axi.M_AXI_ARLEN   = (state_q == ST_AR) ? gen_arlen : 8'd0;
    assign m_axi.M_AXI_RREADY  = (state_q == ST_R);

    logic unused_rid;
    assign unused_rid = |m_axi.M_AXI_RID;
endmodule

// File: tb/tb_tpu_matrix_loader.sv
// Testbench for tpu_matrix_loader: a behavioural AXI read slave backed by a
// small memory, a bus monitor, and one directed task per scenario.
module tb_tpu_matrix_loader;
    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        start;
    logic [31:0] base_addr;
    logic [4:0]  matrix_size;
    logic        busy, done, error, buf_wr_en;
    logic [7:0]  buf_wr_addr;
    logic [31:0] buf_wr_data;

    tpu_matrix_loader_if axi ();

    tpu_matrix_loader dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .start       (start),
        .base_addr   (base_addr),
        .matrix_size (matrix_size),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .buf_wr_en   (buf_wr_en),
        .buf_wr_addr (buf_wr_addr),
        .buf_wr_data (buf_wr_data),
        .m_axi       (axi)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_fail   = 0;

    bit [31:0]   mem  [1024];
    logic [31:0] bufm [256];
    logic [31:0] ar_addr_log [32];
    logic [7:0]  ar_len_log  [32];
    int wr_count, exp_wr_idx, order_viol, ar_count, arvalid_cycles;
    int stab_viol, ovl_viol, done_count, done_cyc, last_wr_cyc, cyc;
    bit stall_en;
    int err_beat, beat_no;

    // slave and monitor state
    bit          s_active, s_pend, ar_hs_prev, r_hs_prev, prev_ar_wait;
    logic [31:0] s_addr, p_addr, hs_addr, prev_araddr;
    logic [7:0]  s_len, p_len, hs_len, prev_arlen;
    int          s_beat;

    // Slave drives right after each falling edge; the monitor samples 1 time
    // unit later, when inputs are settled for the coming rising edge.
    initial begin
        axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = '0;
        axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RLAST = 1'b0; axi.M_AXI_RID = '0;
        cyc = 0; s_active = 0; s_pend = 0; ar_hs_prev = 0; r_hs_prev = 0; prev_ar_wait = 0;
        forever begin
            @(negedge ACLK);
            cyc++;
            if (ARESET === 1'b1) begin
                s_active = 0; s_pend = 0;
                axi.M_AXI_ARREADY = 1'b0; axi.M_AXI_RVALID = 1'b0; axi.M_AXI_RDATA = '0;
                axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RLAST = 1'b0;
            end else begin
                if (ar_hs_prev) begin s_pend = 1; p_addr = hs_addr; p_len = hs_len; end
                if (r_hs_prev) begin
                    s_beat++; beat_no++;
                    if (s_beat > int'(s_len)) s_active = 0;
                end
                if (!s_active && s_pend) begin
                    s_active = 1; s_pend = 0; s_addr = p_addr; s_len = p_len; s_beat = 0;
                end
                axi.M_AXI_ARREADY = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
                axi.M_AXI_RVALID  = s_active && (stall_en ? ($urandom_range(0, 3) != 0) : 1'b1);
                if (s_active) begin
                    axi.M_AXI_RDATA = mem[((s_addr >> 2) + s_beat) & 1023];
                    axi.M_AXI_RRESP = (beat_no == err_beat) ? 2'b10 : 2'b00;
                    axi.M_AXI_RLAST = (s_beat == int'(s_len));
                end else begin
                    axi.M_AXI_RDATA = '0; axi.M_AXI_RRESP = 2'b00; axi.M_AXI_RLAST = 1'b0;
                end
            end
            #1;
            if (axi.M_AXI_ARVALID === 1'b1) arvalid_cycles++;
            if (prev_ar_wait && !(axi.M_AXI_ARVALID === 1'b1 && axi.M_AXI_ARADDR === prev_araddr &&
                                  axi.M_AXI_ARLEN === prev_arlen)) stab_viol++;
            if (axi.M_AXI_ARVALID === 1'b1 && axi.M_AXI_RREADY === 1'b1) ovl_viol++;
            ar_hs_prev = (ARESET !== 1'b1) && axi.M_AXI_ARVALID === 1'b1 && axi.M_AXI_ARREADY === 1'b1;
            r_hs_prev  = (ARESET !== 1'b1) && axi.M_AXI_RVALID === 1'b1 && axi.M_AXI_RREADY === 1'b1;
            prev_ar_wait = (ARESET !== 1'b1) && axi.M_AXI_ARVALID === 1'b1 && axi.M_AXI_ARREADY !== 1'b1;
            prev_araddr = axi.M_AXI_ARADDR; prev_arlen = axi.M_AXI_ARLEN;
            if (ar_hs_prev) begin
                hs_addr = axi.M_AXI_ARADDR; hs_len = axi.M_AXI_ARLEN;
                if (ar_count < 32) begin ar_addr_log[ar_count] = hs_addr; ar_len_log[ar_count] = hs_len; end
                ar_count++;
            end
            if (buf_wr_en === 1'b1 && ARESET !== 1'b1) begin
                if (int'(buf_wr_addr) != exp_wr_idx) order_viol++;
                bufm[buf_wr_addr] = buf_wr_data;
                wr_count++; exp_wr_idx++; last_wr_cyc = cyc;
            end
            if (done === 1'b1) begin done_count++; done_cyc = cyc; end
        end
    end

    task automatic clear_logs();
        wr_count = 0; exp_wr_idx = 0; order_viol = 0; ar_count = 0; arvalid_cycles = 0;
        stab_viol = 0; ovl_viol = 0; done_count = 0; done_cyc = 0; last_wr_cyc = 0;
        beat_no = 0; err_beat = -1; stall_en = 0;
        for (int i = 0; i < 256; i++) bufm[i] = 'x;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [4:0] n);
        @(negedge ACLK); start = 1'b1; base_addr = b; matrix_size = n;
        @(negedge ACLK); start = 1'b0;
    endtask

    task automatic wait_done(output bit got);
        got = 0;
        for (int i = 0; i < 4000; i++) begin
            #2;
            if (done === 1'b1) begin got = 1; break; end
            @(negedge ACLK);
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge ACLK);
        #2;
    endtask

    function automatic int data_mism(input logic [31:0] b, input int cnt);
        int m = 0;
        for (int k = 0; k < cnt; k++)
            if (bufm[k] !== mem[((b >> 2) + k) & 1023]) m++;
        return m;
    endfunction

    task automatic test_reset();
        ARESET = 1'b1; start = 1'b0; base_addr = '0; matrix_size = '0;
        clear_logs();
        repeat (3) @(negedge ACLK);
        #2;
        n_checks++;
        if ({busy, done, error, buf_wr_en, axi.M_AXI_ARVALID, axi.M_AXI_RREADY} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b expected 000000",
                {busy, done, error, buf_wr_en, axi.M_AXI_ARVALID, axi.M_AXI_RREADY});
        end
        n_checks++;
        if ({axi.M_AXI_ARADDR, axi.M_AXI_ARLEN, buf_wr_addr, buf_wr_data} !== 80'd0) begin
            n_fail++; $display("FAIL reset_bus: got araddr %h arlen %h waddr %h wdata %h expected all 0",
                axi.M_AXI_ARADDR, axi.M_AXI_ARLEN, buf_wr_addr, buf_wr_data);
        end
        n_checks++;
        if ({axi.M_AXI_ARID, axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST} !== 6'b0_010_01) begin
            n_fail++; $display("FAIL reset_const: got id/size/burst %b expected 001001",
                {axi.M_AXI_ARID, axi.M_AXI_ARSIZE, axi.M_AXI_ARBURST});
        end
        @(negedge ACLK); ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_n4();
        bit got;
        clear_logs();
        pulse_start(32'h0000_1000, 5'd4);
        #2;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL n4_busy: got %b expected 1", busy); end
        wait_done(got);
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL n4_done_timeout: got no done expected done"); end
        n_checks++;
        if (done_cyc - last_wr_cyc != 1) begin
            n_fail++; $display("FAIL n4_done_latency: got %0d expected 1", done_cyc - last_wr_cyc);
        end
        settle();
        n_checks++;
        if (ar_count != 1 || ar_addr_log[0] !== 32'h1000 || ar_len_log[0] !== 8'd15) begin
            n_fail++; $display("FAIL n4_ar: got %0d bursts addr %h len %0d expected 1 @1000 len 15",
                ar_count, ar_addr_log[0], ar_len_log[0]);
        end
        n_checks++;
        if (wr_count != 16 || order_viol != 0) begin
            n_fail++; $display("FAIL n4_writes: got %0d writes %0d out of order expected 16 in order", wr_count, order_viol);
        end
        n_checks++;
        if (data_mism(32'h1000, 16) != 0) begin
            n_fail++; $display("FAIL n4_data: got %0d bad words expected 0", data_mism(32'h1000, 16));
        end
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b0 || done_count != 1) begin
            n_fail++; $display("FAIL n4_status: got error %b busy %b dones %0d expected 0 0 1", error, busy, done_count);
        end
    endtask

    task automatic test_n5();
        bit got;
        clear_logs();
        pulse_start(32'h0000_2040, 5'd5);
        wait_done(got);
        settle();
        n_checks++;
        if (!got || ar_count != 2) begin n_fail++; $display("FAIL n5_bursts: got %0d done %b expected 2 bursts", ar_count, got); end
        n_checks++;
        if (ar_addr_log[0] !== 32'h2040 || ar_len_log[0] !== 8'd15) begin
            n_fail++; $display("FAIL n5_burst0: got %h len %0d expected 2040 len 15", ar_addr_log[0], ar_len_log[0]);
        end
        n_checks++;
        if (ar_addr_log[1] !== 32'h2080 || ar_len_log[1] !== 8'd8) begin
            n_fail++; $display("FAIL n5_burst1: got %h len %0d expected 2080 len 8", ar_addr_log[1], ar_len_log[1]);
        end
        n_checks++;
        if (wr_count != 25 || order_viol != 0 || data_mism(32'h2040, 25) != 0) begin
            n_fail++; $display("FAIL n5_data: got %0d writes %0d bad expected 25 writes 0 bad", wr_count, data_mism(32'h2040, 25));
        end
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL n5_error: got %b expected 0", error); end
    endtask

    task automatic test_n16_stalls();
        bit got;
        int bad_bursts = 0;
        clear_logs();
        stall_en = 1;
        pulse_start(32'h0000_0400, 5'd16);
        wait_done(got);
        settle();
        stall_en = 0;
        for (int i = 0; i < 16; i++)
            if (ar_addr_log[i] !== 32'h400 + 32'(i) * 32'h40 || ar_len_log[i] !== 8'd15) bad_bursts++;
        n_checks++;
        if (!got || ar_count != 16 || bad_bursts != 0) begin
            n_fail++; $display("FAIL n16_bursts: got %0d bursts %0d wrong done %b expected 16 bursts 0 wrong", ar_count, bad_bursts, got);
        end
        n_checks++;
        if (stab_viol != 0 || ovl_viol != 0) begin
            n_fail++; $display("FAIL n16_ar_stable: got %0d unstable %0d overlap expected 0 0", stab_viol, ovl_viol);
        end
        n_checks++;
        if (wr_count != 256 || order_viol != 0 || data_mism(32'h400, 256) != 0) begin
            n_fail++; $display("FAIL n16_data: got %0d writes %0d bad expected 256 writes 0 bad", wr_count, data_mism(32'h400, 256));
        end
        n_checks++;
        if (error !== 1'b0 || done_count != 1) begin
            n_fail++; $display("FAIL n16_status: got error %b dones %0d expected 0 1", error, done_count);
        end
    endtask

    task automatic test_slverr();
        bit got;
        clear_logs();
        err_beat = 3;
        pulse_start(32'h0000_0100, 5'd4);
        wait_done(got);
        settle();
        n_checks++;
        if (!got || wr_count != 3 || data_mism(32'h100, 3) != 0) begin
            n_fail++; $display("FAIL err_writes: got %0d writes done %b expected 3 good writes", wr_count, got);
        end
        n_checks++;
        if (error !== 1'b1 || busy !== 1'b0 || done_count != 1) begin
            n_fail++; $display("FAIL err_status: got error %b busy %b dones %0d expected 1 0 1", error, busy, done_count);
        end
        clear_logs();
        pulse_start(32'h0000_0200, 5'd2);
        #2;
        n_checks++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", error); end
        wait_done(got);
        settle();
        n_checks++;
        if (!got || wr_count != 4 || ar_len_log[0] !== 8'd3 || data_mism(32'h200, 4) != 0 || error !== 1'b0) begin
            n_fail++; $display("FAIL err_recover: got %0d writes len %0d error %b expected 4 writes len 3 error 0",
                wr_count, ar_len_log[0], error);
        end
    endtask

    task automatic test_bad_size();
        bit got;
        logic [4:0] sizes [2];
        sizes[0] = 5'd0; sizes[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            clear_logs();
            pulse_start(32'h0000_3000, sizes[i]);
            wait_done(got);
            settle();
            n_checks++;
            if (!got || arvalid_cycles != 0 || done_count != 1) begin
                n_fail++; $display("FAIL badsize_%0d_traffic: got arvalid cycles %0d dones %0d expected 0 1",
                    sizes[i], arvalid_cycles, done_count);
            end
            n_checks++;
            if (error !== 1'b1 || busy !== 1'b0 || wr_count != 0) begin
                n_fail++; $display("FAIL badsize_%0d_status: got error %b busy %b writes %0d expected 1 0 0",
                    sizes[i], error, busy, wr_count);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit got;
        clear_logs();
        pulse_start(32'h0000_0300, 5'd2);
        for (int i = 0; i < 3; i++) begin
            start = 1'b1; base_addr = 32'h0000_3F00; matrix_size = 5'd3;
            @(negedge ACLK);
        end
        start = 1'b0;
        wait_done(got);
        repeat (6) @(negedge ACLK);
        #2;
        n_checks++;
        if (!got || ar_count != 1 || ar_addr_log[0] !== 32'h300 || ar_len_log[0] !== 8'd3) begin
            n_fail++; $display("FAIL b2b_ar: got %0d bursts addr %h len %0d expected 1 @300 len 3",
                ar_count, ar_addr_log[0], ar_len_log[0]);
        end
        n_checks++;
        if (wr_count != 4 || done_count != 1 || data_mism(32'h300, 4) != 0) begin
            n_fail++; $display("FAIL b2b_single: got %0d writes %0d dones expected 4 writes 1 done", wr_count, done_count);
        end
    endtask

    task automatic test_reset_mid_r();
        bit got;
        bit reached = 0;
        clear_logs();
        pulse_start(32'h0000_0800, 5'd16);
        for (int i = 0; i < 200; i++) begin
            #2;
            if (wr_count >= 5) begin reached = 1; break; end
            @(negedge ACLK);
        end
        n_checks++;
        if (!reached || axi.M_AXI_RREADY !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_reach: got writes %0d rready %b expected >=5 1", wr_count, axi.M_AXI_RREADY);
        end
        @(negedge ACLK); ARESET = 1'b1;
        @(negedge ACLK); #2;
        n_checks++;
        if ({busy, done, error, buf_wr_en, axi.M_AXI_ARVALID, axi.M_AXI_RREADY} !== 6'b0) begin
            n_fail++; $display("FAIL rst_mid_ctrl: got %b expected 000000",
                {busy, done, error, buf_wr_en, axi.M_AXI_ARVALID, axi.M_AXI_RREADY});
        end
        n_checks++;
        if ({axi.M_AXI_ARADDR, axi.M_AXI_ARLEN, buf_wr_addr, buf_wr_data} !== 80'd0 || done_count != 0) begin
            n_fail++; $display("FAIL rst_mid_bus: got araddr %h arlen %h waddr %h wdata %h dones %0d expected 0",
                axi.M_AXI_ARADDR, axi.M_AXI_ARLEN, buf_wr_addr, buf_wr_data, done_count);
        end
        @(negedge ACLK); ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        clear_logs();
        pulse_start(32'h0000_0040, 5'd2);
        wait_done(got);
        settle();
        n_checks++;
        if (!got || ar_count != 1 || ar_addr_log[0] !== 32'h40 || wr_count != 4 ||
            data_mism(32'h40, 4) != 0 || error !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_reload: got %0d bursts %0d writes error %b expected 1 4 0",
                ar_count, wr_count, error);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_0003);
        test_reset();
        test_n4();
        test_n5();
        test_n16_stalls();
        test_slverr();
        test_bad_size();
        test_back_to_back();
        test_reset_mid_r();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tpu_matrix_loader.md
TPU_MATRIX_LOADER -- requirements
Module: tpu_matrix_loader

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-high.
REQ-002 SHALL have these parameters (name, default, meaning), one per line:
- C_M_AXI_ADDR_WIDTH, 32, AXI address width.
- C_M_AXI_DATA_WIDTH, 32, AXI data width (one matrix element per beat).
- C_M_AXI_ID_WIDTH, 1, AXI ID width.
- C_M_AXI_BURST_LEN, 16, maximum beats per burst.
- MAX_MATRIX_SIZE, 16, largest supported N for an NxN matrix.
REQ-003 SHALL have these ports (name, direction, width, meaning), one per line:
- ACLK in 1: clock.
- ARESET in 1: synchronous active-high reset.
- start in 1: one-cycle load request.
- base_addr in 32: matrix byte address; 64-byte aligned.
- matrix_size in 5: N, legal range 1..16.
- busy out 1: load in progress.
- done out 1: one-cycle completion pulse.
- error out 1: sticky failure flag; cleared by the next accepted start.
- buf_wr_en out 1: element-buffer write strobe.
- buf_wr_addr out 8: element index, row-major.
- buf_wr_data out 32: element value.
- M_AXI_ARID out 1: constant 0.
- M_AXI_ARADDR out 32: burst start address.
- M_AXI_ARLEN out 8: beats-1.
- M_AXI_ARSIZE out 3: constant 3'b010.
- M_AXI_ARBURST out 2: constant 2'b01 (INCR).
- M_AXI_ARVALID out 1: address valid.
- M_AXI_ARREADY in 1: address ready.
- M_AXI_RID in 1: ignored.
- M_AXI_RDATA in 32: read data.
- M_AXI_RRESP in 2: read response.
- M_AXI_RLAST in 1: last beat of burst.
- M_AXI_RVALID in 1: data valid.
- M_AXI_RREADY out 1: data ready.
REQ-004 SHALL NOT drive LOCK/CACHE/PROT/QOS/USER; these are tied off at integration.

Function
REQ-005 SHALL fetch N*N 32-bit words from base_addr into buf_wr_addr 0..N*N-1, in order.
REQ-006 SHALL use the states:
- IDLE: waits for start.
- AR: ARVALID held until ARREADY.
- R: RREADY=1, accepting beats.
- FIN: one cycle, done=1, then IDLE.
REQ-007 SHALL, on start in IDLE with N in 1..16:
- latch base_addr and N;
- compute total=N*N (9 bits, max 256);
- clear error, set busy;
- enter AR on the next cycle.
REQ-008 SHALL set burst beats = min(16, remaining); ARLEN = beats-1; ARADDR = base + 64*burst_index.
REQ-009 SHALL hold ARADDR/ARLEN stable while ARVALID=1 and ARREADY=0; it SHALL keep at most one burst outstanding.
REQ-010 SHALL, per beat accepted (RVALID & RREADY):
- in the same cycle, drive buf_wr_en=1, buf_wr_data=RDATA, buf_wr_addr=running index;
- increment the index.
REQ-011 SHALL end a burst at the beat whose count equals ARLEN+1; then go to AR if words remain, else FIN.
REQ-012 SHALL set error=1, complete the current burst's beats without writing them, and skip remaining bursts going to FIN, when:
- RRESP != 2'b00, or
- RLAST disagrees with the beat count.
REQ-013 SHALL, on start with N=0 or N>16: issue no AXI traffic, go directly to FIN, set error=1.
REQ-014 SHALL ignore start while busy=1.
REQ-015 SHALL drive busy=1 in AR, R and FIN, and 0 in IDLE.
REQ-016 SHALL keep RREADY=0 outside R and SHALL NOT drive ARVALID and RREADY in the same cycle.
REQ-017 SHALL never cross a 4 KB boundary (guaranteed by 64-byte alignment and bursts of at most 16 beats).

Reset
REQ-018 SHALL, while ARESET=1 at a clock edge:
- return to IDLE;
- drive busy, done, error, buf_wr_en, ARVALID, RREADY to 0;
- drive ARADDR, ARLEN, buf_wr_addr, buf_wr_data to 0.
REQ-019 SHALL abandon a load interrupted by reset without completion signalling; the AXI fabric is reset on the same signal.

Structure
REQ-020 SHALL take state encodings, AXI constants (INCR, SIZE_4B, RESP_OKAY) and MAX_MATRIX_SIZE from the shared package tpu_axi_pkg.
REQ-021 SHALL be a single module; the burst-length/address generator MAY be a sub-module named tpu_burst_gen.

Verification
REQ-022 SHALL cover N=4, zero-wait slave -> one burst (ARADDR=base, ARLEN=15), 16 buffer writes to addresses 0..15, done 1 cycle after the last beat, error=0.
REQ-023 SHALL cover N=5 -> bursts ARLEN=15 @base, then ARLEN=8 @base+0x40; 25 writes; data matches memory.
REQ-024 SHALL cover N=16 with random ARREADY/RVALID stalls -> 16 bursts of 16 beats, addresses step 0x40, ARADDR/ARLEN stable during stalls, 256 writes.
REQ-025 SHALL cover N=4 with RRESP=SLVERR on beat 3 -> 3 writes only, error=1, done pulses, busy drops; the next good start clears error.
REQ-026 SHALL cover N=0, and start repeated while busy -> N=0: no ARVALID, done+error; repeated start: ignored, single load.
REQ-027 SHALL cover ARESET asserted mid-R -> all outputs reach their reset values at the next edge; a following N=2 load completes normally.
